// File: rtl/rapids_mmu_arb.sv
// rtl/rapids_mmu_arb.sv - Rapids MMU with shared main-memory arbitration and pipelined responses
// Optional fault log enabled by defining MMU_FAULT_LOG_EN.
module rapids_mmu_arb #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 32,
    parameter int SPECIAL_WORDS = 15,
    parameter int MEM_BASE      = 16,
    parameter int MEM_WORDS     = 128,
    parameter int READ_LAT      = 1
) (
    input  logic                clk,
    input  logic                reset,
`ifdef MMU_FAULT_LOG_EN
    input  logic                fault_clr,
    output logic [ADDR_W-1:0]   fault_addr,
    output logic                fault_src,
    output logic                fault_pending,
`endif
    input  logic                instr_req,
    input  logic [ADDR_W-1:0]   instr_addr,
    input  logic                data_rd,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] data_be,
    output logic [DATA_W-1:0]   instr,
    output logic                instr_valid,
    output logic                instr_segv,
    output logic [DATA_W-1:0]   data,
    output logic                data_valid,
    output logic                data_segv,
    output logic                wait_instr,
    output logic                wait_data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int SP_W  = (SPECIAL_WORDS > 1) ? $clog2(SPECIAL_WORDS) : 1;

    // One extra bit so the upper bound never wraps at full ADDR_W.
    localparam logic [ADDR_W:0] MEM_LO = (ADDR_W+1)'(MEM_BASE);
    localparam logic [ADDR_W:0] MEM_HI = (ADDR_W+1)'(MEM_BASE + MEM_WORDS);
    localparam logic [ADDR_W:0] SP_HI  = (ADDR_W+1)'(SPECIAL_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS] = '{default: '0};
    logic [DATA_W-1:0] special [SPECIAL_WORDS];

    logic [ADDR_W:0]  ia_x, da_x;
    logic             i_main, d_main, d_spec, d_seg, i_seg;
    logic [IDX_W-1:0] i_idx, d_idx;
    logic [SP_W-1:0]  sp_idx;
    logic             d_req, contend, instr_prio, i_acc, d_acc;
    logic [DATA_W-1:0] i_rdata, d_rdata;

    assign ia_x   = {1'b0, instr_addr};
    assign da_x   = {1'b0, data_addr};
    assign i_main = (instr_addr == '0) || (ia_x >= MEM_LO && ia_x < MEM_HI);
    assign i_seg  = ~i_main;
    assign i_idx  = (instr_addr == '0) ? '0 : IDX_W'(instr_addr - ADDR_W'(MEM_BASE));
    assign d_main = (da_x >= MEM_LO) && (da_x < MEM_HI);
    assign d_spec = (data_addr != '0) && (da_x <= SP_HI);
    assign d_seg  = ~d_main & ~d_spec;
    assign d_idx  = IDX_W'(data_addr - ADDR_W'(MEM_BASE));
    assign sp_idx = SP_W'(data_addr - ADDR_W'(1));

    // Only main-memory traffic shares the single RAM port.
    assign d_req      = data_rd | data_wr;
    assign contend    = instr_req & i_main & d_req & d_main;
    assign wait_instr = contend & ~instr_prio;
    assign wait_data  = contend & instr_prio;
    assign i_acc      = instr_req & ~wait_instr;
    assign d_acc      = d_req & ~wait_data;

    always_comb begin
        i_rdata = '0;
        if (i_main) i_rdata = mem[i_idx];
    end

    always_comb begin
        d_rdata = '0;
        if (!data_wr && d_main)      d_rdata = mem[d_idx];
        else if (!data_wr && d_spec) d_rdata = special[sp_idx];
    end

    always_ff @(posedge clk) begin
        if (d_acc && data_wr && d_main) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data_be[b]) mem[d_idx][8*b +: 8] <= data_in[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SPECIAL_WORDS; s++) special[s] <= '0;
        end else if (d_acc && data_wr && d_spec) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data_be[b]) special[sp_idx][8*b +: 8] <= data_in[8*b +: 8];
            end
        end
    end

    // Response pipelines: a stage loads data only when a valid enters it, so the
    // final stage doubles as the hold-last-value output register.
    logic [READ_LAT-1:0] i_pv, d_pv;
    logic [DATA_W:0]     i_pd [READ_LAT];
    logic [DATA_W:0]     d_pd [READ_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_prio <= 1'b0;
            i_pv       <= '0;
            d_pv       <= '0;
            for (int k = 0; k < READ_LAT; k++) begin
                i_pd[k] <= '0;
                d_pd[k] <= '0;
            end
        end else begin
            instr_prio <= wait_instr;
            i_pv[0]    <= i_acc;
            d_pv[0]    <= d_acc;
            if (i_acc) i_pd[0] <= {i_seg, i_rdata};
            if (d_acc) d_pd[0] <= {d_seg, d_rdata};
            for (int k = 1; k < READ_LAT; k++) begin
                i_pv[k] <= i_pv[k-1];
                d_pv[k] <= d_pv[k-1];
                if (i_pv[k-1]) i_pd[k] <= i_pd[k-1];
                if (d_pv[k-1]) d_pd[k] <= d_pd[k-1];
            end
        end
    end

    assign instr_valid          = i_pv[READ_LAT-1];
    assign {instr_segv, instr}  = i_pd[READ_LAT-1];
    assign data_valid           = d_pv[READ_LAT-1];
    assign {data_segv, data}    = d_pd[READ_LAT-1];

`ifdef MMU_FAULT_LOG_EN
    // Data faults take precedence over instruction faults in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_addr    <= '0;
            fault_src     <= 1'b0;
            fault_pending <= 1'b0;
        end else if (fault_clr) begin
            fault_pending <= 1'b0;
        end else if (!fault_pending) begin
            if (d_acc && d_seg) begin
                fault_addr    <= data_addr;
                fault_src     <= 1'b1;
                fault_pending <= 1'b1;
            end else if (i_acc && i_seg) begin
                fault_addr    <= instr_addr;
                fault_src     <= 1'b0;
                fault_pending <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rapids_mmu_arb.sv
// tb/tb_rapids_mmu_arb.sv - scoreboard bench for rapids_mmu_arb at READ_LAT 1 and 3
module tb_rapids_mmu_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req = 1'b0, data_rd = 1'b0, data_wr = 1'b0;
    logic [31:0] instr_addr = '0, data_addr = '0, data_in = '0;
    logic [3:0]  data_be = '0;

    logic [31:0] instr1, data1, instr3, data3;
    logic        instr_valid1, instr_segv1, data_valid1, data_segv1, wait_instr1, wait_data1;
    logic        instr_valid3, instr_segv3, data_valid3, data_segv3, wait_instr3, wait_data3;

    always #5 clk = ~clk;

    rapids_mmu_arb #(.READ_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr),
        .data_in(data_in), .data_be(data_be),
        .instr(instr1), .instr_valid(instr_valid1), .instr_segv(instr_segv1),
        .data(data1), .data_valid(data_valid1), .data_segv(data_segv1),
        .wait_instr(wait_instr1), .wait_data(wait_data1)
    );

    rapids_mmu_arb #(.READ_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr),
        .data_in(data_in), .data_be(data_be),
        .instr(instr3), .instr_valid(instr_valid3), .instr_segv(instr_segv3),
        .data(data3), .data_valid(data_valid3), .data_segv(data_segv3),
        .wait_instr(wait_instr3), .wait_data(wait_data3)
    );

    typedef struct {
        logic [31:0] val;
        logic        segv;
        int          acc;
    } exp_t;

    // Queues: 0 = instr LAT1, 1 = data LAT1, 2 = instr LAT3, 3 = data LAT3.
    exp_t        q [4][$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt = 0;
    logic [31:0] mmem [128];
    logic [31:0] msp [15];
    logic        m_prev = 1'b0;
    logic        wi, wd;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int k, input string tag, input logic v, input logic [31:0] d,
                       input logic s, input int lat);
        exp_t e;
        if (v) begin
            if (q[k].size() == 0) begin
                check({tag, "_spurious_valid"}, {31'b0, v}, 32'd0);
            end else begin
                e = q[k].pop_front();
                check({tag, "_data"}, d, e.val);
                check({tag, "_segv"}, {31'b0, s}, {31'b0, e.segv});
                check({tag, "_latency"}, cnt, e.acc + lat);
            end
        end else if (q[k].size() > 0 && cnt > q[k][0].acc + lat) begin
            check({tag, "_missing_valid"}, {31'b0, v}, 32'd1);
            void'(q[k].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, "i1", instr_valid1, instr1, instr_segv1, 1);
        mon(1, "d1", data_valid1,  data1,  data_segv1,  1);
        mon(2, "i3", instr_valid3, instr3, instr_segv3, 3);
        mon(3, "d3", data_valid3,  data3,  data_segv3,  3);
    end

    task automatic step(input logic ir, input logic [31:0] ia, input logic rd, input logic wr,
                        input logic [31:0] da, input logic [31:0] din, input logic [3:0] be,
                        output logic owi, output logic owd);
        exp_t ei, ed;
        logic im, dm, ds, dreq, cont, ewi, ewd;
        @(negedge clk);
        instr_req = ir; instr_addr = ia; data_rd = rd; data_wr = wr;
        data_addr = da; data_in = din; data_be = be;
        #1;
        im   = (ia == 0) || (ia >= 16 && ia < 144);
        dm   = (da >= 16 && da < 144);
        ds   = (da >= 1 && da <= 15);
        dreq = rd | wr;
        cont = ir & im & dreq & dm;
        ewi  = cont & ~m_prev;
        ewd  = cont & m_prev;
        owi  = wait_instr1;
        owd  = wait_data1;
        check("wait_instr1", {31'b0, wait_instr1}, {31'b0, ewi});
        check("wait_data1",  {31'b0, wait_data1},  {31'b0, ewd});
        check("wait_instr3", {31'b0, wait_instr3}, {31'b0, ewi});
        check("wait_data3",  {31'b0, wait_data3},  {31'b0, ewd});
        if (ir && !ewi) begin
            ei.acc  = cnt;
            ei.segv = ~im;
            ei.val  = im ? mmem[(ia == 0) ? 0 : int'(ia) - 16] : 32'd0;
            q[0].push_back(ei);
            q[2].push_back(ei);
        end
        if (dreq && !ewd) begin
            ed.acc  = cnt;
            ed.segv = ~(dm | ds);
            ed.val  = (wr || ed.segv) ? 32'd0 : (dm ? mmem[int'(da) - 16] : msp[int'(da) - 1]);
            q[1].push_back(ed);
            q[3].push_back(ed);
            for (int b = 0; b < 4; b++) begin
                if (wr && be[b] && dm) mmem[int'(da) - 16][8*b +: 8] = din[8*b +: 8];
                if (wr && be[b] && ds) msp[int'(da) - 1][8*b +: 8]   = din[8*b +: 8];
            end
        end
        m_prev = ewi;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mmem[i] = '0;
        for (int i = 0; i < 15; i++)  msp[i]  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_instr1", instr1, 32'd0);
        check("rst_data1",  data1,  32'd0);
        check("rst_valids1", {28'b0, instr_valid1, instr_segv1, data_valid1, data_segv1}, 32'd0);
        check("rst_valids3", {28'b0, instr_valid3, instr_segv3, data_valid3, data_segv3}, 32'd0);
        reset = 1'b0;

        // write then read back
        step(0, 0, 0, 1, 20, 32'hDEADBEEF, 4'hF, wi, wd);
        step(0, 0, 1, 0, 20, 0, 0, wi, wd);
        idle(5);

        // byte enables: expect 0x11BB33DD
        step(0, 0, 0, 1, 20, 32'h11223344, 4'hF, wi, wd);
        step(0, 0, 0, 1, 20, 32'hAABBCCDD, 4'b0101, wi, wd);
        step(0, 0, 1, 0, 20, 0, 0, wi, wd);
        idle(5);

        // arbitration: data, instr, data, instr
        for (int i = 0; i < 4; i++) begin
            step(1, 16, 1, 0, 17, 0, 0, wi, wd);
            check($sformatf("arb_wait_instr_c%0d", i), {31'b0, wi}, {31'b0, logic'(i % 2 == 0)});
            check($sformatf("arb_wait_data_c%0d", i),  {31'b0, wd}, {31'b0, logic'(i % 2 == 1)});
        end
        idle(5);

        // faults; the out-of-range write must leave mem[0] alone
        step(0, 0, 1, 0, 0, 0, 0, wi, wd);
        step(1, 5, 0, 0, 0, 0, 0, wi, wd);
        step(0, 0, 0, 1, 144, 32'hFFFFFFFF, 4'hF, wi, wd);
        step(1, 0, 0, 0, 0, 0, 0, wi, wd);
        step(0, 0, 0, 1, 32'h0001_0010, 32'hFFFFFFFF, 4'hF, wi, wd);
        step(0, 0, 1, 0, 16, 0, 0, wi, wd);
        idle(5);

        // special register with concurrent fetch
        step(0, 0, 0, 1, 3, 32'h5, 4'hF, wi, wd);
        step(1, 16, 1, 0, 3, 0, 0, wi, wd);
        check("special_wait_instr", {31'b0, wi}, 32'd0);
        idle(6);

        // reset while a read is in flight in the LAT3 instance
        step(0, 0, 1, 0, 3, 0, 0, wi, wd);
        @(negedge clk);
        #2;
        reset = 1'b1;
        data_rd = 1'b0;
        for (int k = 0; k < 4; k++) q[k].delete();
        for (int i = 0; i < 15; i++) msp[i] = '0;
        m_prev = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(6);
        step(0, 0, 1, 0, 3, 0, 0, wi, wd);
        idle(6);

        check("drain_queues", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rapids_mmu_arb.md
Name: rapids_mmu_arb

Overview:
- Parametrised successor to the Rapids linear-memory MMU, with the same address map.
  - Word 0 is the boot vector.
  - Words 1..SPECIAL_WORDS are the special register file.
  - Main memory is a linear segment at MEM_BASE.
- Adds a real request/valid handshake, configurable read latency, byte-enabled writes and a single-port main memory shared between instruction and data with fair arbitration.
- Sits between the core's fetch and load/store stages and on-chip RAM.

Parameters:
- DATA_W, 32: data/instruction word width; must be a multiple of 8.
- ADDR_W, 32: word-address width.
- SPECIAL_WORDS, 15: number of special registers (addresses 1..SPECIAL_WORDS).
- MEM_BASE, 16: first main-memory address; must be greater than SPECIAL_WORDS.
- MEM_WORDS, 128: main-memory depth in words.
- READ_LAT, 1: response latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr_req  in  1  fetch request
- instr_addr  in  ADDR_W  fetch word address
- data_rd  in  1  data read request
- data_wr  in  1  data write request
- data_addr  in  ADDR_W  data word address
- data_in  in  DATA_W  write data
- data_be  in  DATA_W/8  byte enables for writes
- instr  out  DATA_W  fetched word
- instr_valid  out  1  fetch response strobe
- instr_segv  out  1  fetch fault, qualified by instr_valid
- data  out  DATA_W  read data
- data_valid  out  1  data response strobe (reads and writes)
- data_segv  out  1  data fault, qualified by data_valid
- wait_instr  out  1  fetch not accepted this cycle
- wait_data  out  1  data access not accepted this cycle

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high.
- Reset values:
  - instr, data, all *_valid and *_segv: 0.
  - Response pipeline flushed.
  - Special registers cleared to 0.
  - Main memory is not reset; it is zero only at elaboration.
- Reset mid-operation: in-flight responses are dropped; no valid is issued for them after reset deasserts.
- Address decode, instruction port:
  - Address 0 maps to mem[0].
  - Addresses MEM_BASE..MEM_BASE+MEM_WORDS-1 map to mem[a-MEM_BASE].
  - Anything else, including the special range, is a fault.
- Address decode, data port:
  - Address 0 is a fault.
  - Addresses 1..SPECIAL_WORDS map to special[a-1].
  - The main range maps as for the instruction port.
  - Anything else is a fault; addresses between SPECIAL_WORDS+1 and MEM_BASE-1 are faults.
- Data request rule: data_rd and data_wr together are treated as a write; read data is 0.
- Acceptance:
  - A request is accepted in any cycle it is high and its wait_* output is low (wait_* is combinational).
  - The requester holds address, data and enables stable while wait_* is high.
- Arbitration:
  - Only main-memory accesses contend; special and faulting accesses never wait.
  - When both ports target main memory, data wins unless instr was denied in the previous cycle, in which case instr wins.
  - The loser's wait_* is high.
- Writes:
  - Committed at the clock edge of acceptance.
  - Only bytes with data_be=1 are updated.
  - Special-register writes also honour data_be.
  - Writes to faulting addresses have no effect.
- Responses:
  - Exactly READ_LAT cycles after acceptance, *_valid pulses high for 1 cycle with data/instr and segv.
  - Reads return the value before any same-edge write.
  - Faults return 0 with segv=1.
  - Outputs hold their last value when valid is low.
- Throughput: fully pipelined; one accepted request per port per cycle; responses are returned in order.
- Width rule: address comparisons use the full ADDR_W with no truncation; an address of MEM_BASE+MEM_WORDS or above is a fault even if the low bits alias.

Optional Feature:
- Macro: MMU_FAULT_LOG_EN.
- When defined:
  - Adds output fault_addr (ADDR_W), output fault_src (1: 0=instr, 1=data), output fault_pending (1) and input fault_clr (1).
  - The first fault accepted (at acceptance, data over instr in the same cycle) is latched and fault_pending is set.
  - Later faults are ignored until fault_clr is high at a clock edge.
  - fault_clr takes priority over a new fault in the same cycle.
  - All three outputs reset to 0.
- When undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset then write, READ_LAT=1: data_wr to 20 with data_in=0xDEADBEEF and be=0xF, then data_rd 20 → data_valid 1 cycle later each time, and the read returns 0xDEADBEEF with data_segv=0.
- Byte enables: write 0x11223344 to 20, then write 0xAABBCCDD with be=0b0101, then read → 0x11BB33DD.
- Arbitration: instr_req to 16 and data_rd to 17 held high for 4 cycles:
  - wait_instr must be high in cycle 0 and wait_data high in cycle 1.
  - Grants alternate data, instr, data, instr.
  - No port waits 2 consecutive cycles.
- Faults:
  - data_rd at 0 → data_segv=1, data=0.
  - instr_req at 5 → instr_segv=1.
  - data_wr at 144 (MEM_BASE+MEM_WORDS) → segv=1, and mem[0] is unchanged.
- Special registers and latency: with READ_LAT=3, data_wr 0x5 to address 3, then read 3 → data_valid exactly 3 cycles after acceptance with value 0x5; concurrent instr_req to 16 sees wait_instr=0.
- Reset mid-flight: READ_LAT=3, accept a read, assert reset 1 cycle later → no data_valid ever appears for that read; special[2] reads 0 after reset.
